// File: rtl/ec_pkg.sv
// ---------------------------------------------------------------------------
// ec_pkg
// Shared types and sizing for the encode-engine datapath.
//   packet_t        one PACKET_LENGTH-bit stream beat
//   eng_result_t    one engine result: M_MAX parity units x W packets,
//                   indexed [unit][packet]
//   outbuf_state_e  serialiser state of eng_outbuf
//   clamp_m_active  maps an out-of-range active-unit count onto M_MAX
// ---------------------------------------------------------------------------
package ec_pkg;

    localparam int PACKET_LENGTH          = 32;
    localparam int W                      = 4;
    localparam int PCK_TREE_XOR_UNITS_NUM = 2;
    localparam int M_MAX                  = PCK_TREE_XOR_UNITS_NUM;
    localparam int DEPTH                  = 4;
    localparam int M_W                    = $clog2(PCK_TREE_XOR_UNITS_NUM + 1);

    // Index widths sized exactly to the arrays they select from.
    localparam int U_W   = (M_MAX > 1) ? $clog2(M_MAX) : 1;
    localparam int B_W   = (W > 1) ? $clog2(W) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PACKET_LENGTH-1:0] packet_t;
    typedef packet_t [M_MAX-1:0][W-1:0] eng_result_t;

    typedef enum logic {
        OB_IDLE,
        OB_STREAM
    } outbuf_state_e;

    // Zero active units would produce an entry with no beats, so zero and
    // anything above M_MAX both fall back to draining every unit.
    function automatic logic [M_W-1:0] clamp_m_active(input logic [M_W-1:0] m);
        if (m == '0 || m > M_W'(M_MAX)) begin
            return M_W'(M_MAX);
        end
        return m;
    endfunction

endpackage

// File: rtl/eng_outbuf_fifo_mem.sv
// ---------------------------------------------------------------------------
// eng_outbuf_fifo_mem
// DEPTH-entry storage for whole engine results with read/write pointers and
// an occupancy count.
//   clk, rstn   clock, async active-low reset
//   clr         sync clear of pointers and count
//   push        store push_data at wr_ptr (caller guarantees not full)
//   push_data   engine result to store
//   pop         release the head entry (caller guarantees not empty)
//   head_data   entry at rd_ptr
//   next_data   entry at rd_ptr+1, used to start the following entry
//               without a bubble
//   count       occupancy 0..DEPTH
//   full/empty  derived from the registered count only
// ---------------------------------------------------------------------------
module eng_outbuf_fifo_mem
    import ec_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              push,
    input  eng_result_t       push_data,
    input  logic              pop,
    output eng_result_t       head_data,
    output eng_result_t       next_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    eng_result_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage carries no reset; only occupied slots are ever read out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop on the same edge leave the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + PTR_W'(1)];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/eng_outbuf.sv
// ---------------------------------------------------------------------------
// eng_outbuf
// Parity output buffer after the encode engine. Each accepted write stores a
// full engine result; the serialiser drains cfg_m_active parity units of W
// packets each onto a valid/ready stream, unit-major, packet-minor.
//   clk, rstn            clock, async active-low reset
//   outbuf_clr           sync clear: empties the FIFO and aborts the stream
//   cfg_m_active         units drained per entry, sampled at entry start
//   eng_outbuf_dout_reg  engine result to store
//   eng_outbuf_wr_req    engine write request
//   outbuf_eng_wr_ack    write accepted this cycle (combinational)
//   outbuf_eng_full      no free entry
//   outbuf_empty         FIFO empty and no stream in progress
//   out_data/out_valid/out_last/out_ready   registered packet stream
// Optional build macro OUTBUF_STATS_EN adds stat_wr_cnt, stat_rd_cnt and the
// sticky stat_ovf flag.
// ---------------------------------------------------------------------------
module eng_outbuf
    import ec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     outbuf_clr,
    input  logic [M_W-1:0]           cfg_m_active,
    input  eng_result_t              eng_outbuf_dout_reg,
    input  logic                     eng_outbuf_wr_req,
    output logic                     outbuf_eng_wr_ack,
    output logic                     outbuf_eng_full,
    output logic                     outbuf_empty,
    output logic [PACKET_LENGTH-1:0] out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready
`ifdef OUTBUF_STATS_EN
    ,
    output logic [31:0]              stat_wr_cnt,
    output logic [31:0]              stat_rd_cnt,
    output logic                     stat_ovf
`endif
);

    outbuf_state_e          state, state_n;
    logic [M_W-1:0]         m_lat, m_lat_n;
    logic [U_W-1:0]         u, u_n;
    logic [B_W-1:0]         b, b_n;
    logic                   out_valid_n;
    logic                   out_last_n;
    logic [PACKET_LENGTH-1:0] out_data_n;

    eng_result_t            head_data;
    eng_result_t            next_data;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   beat_done;

    // Full is judged on the registered count, so a slot freed by a pop on
    // this edge only becomes writable on the next cycle.
    assign push              = eng_outbuf_wr_req & ~fifo_full & ~outbuf_clr;
    assign outbuf_eng_wr_ack = push;
    assign outbuf_eng_full   = fifo_full;
    assign outbuf_empty      = fifo_empty & (state == OB_IDLE);

    assign beat_done = (state == OB_STREAM) & out_valid & out_ready;
    assign pop       = beat_done & out_last & ~outbuf_clr;

    eng_outbuf_fifo_mem u_fifo_mem (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (outbuf_clr),
        .push      (push),
        .push_data (eng_outbuf_dout_reg),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Serialiser next state. The stream outputs are registered, so the data
    // for the beat that will be shown after this edge is selected here: the
    // head entry when starting or advancing, the entry behind the head when
    // the last beat is taken and another entry is already waiting.
    always_comb begin
        state_n    = state;
        m_lat_n    = m_lat;
        u_n        = u;
        b_n        = b;
        out_data_n = out_data;

        if (outbuf_clr) begin
            state_n    = OB_IDLE;
            u_n        = '0;
            b_n        = '0;
            out_data_n = '0;
        end else begin
            case (state)
                OB_IDLE: begin
                    if (!fifo_empty) begin
                        state_n    = OB_STREAM;
                        m_lat_n    = clamp_m_active(cfg_m_active);
                        u_n        = '0;
                        b_n        = '0;
                        out_data_n = head_data[0][0];
                    end
                end
                OB_STREAM: begin
                    if (beat_done) begin
                        if (out_last) begin
                            if (fifo_count > CNT_W'(1)) begin
                                m_lat_n    = clamp_m_active(cfg_m_active);
                                u_n        = '0;
                                b_n        = '0;
                                out_data_n = next_data[0][0];
                            end else begin
                                state_n    = OB_IDLE;
                                u_n        = '0;
                                b_n        = '0;
                                out_data_n = '0;
                            end
                        end else begin
                            if (b == B_W'(W - 1)) begin
                                b_n = '0;
                                u_n = u + U_W'(1);
                            end else begin
                                b_n = b + B_W'(1);
                            end
                            out_data_n = head_data[u_n][b_n];
                        end
                    end
                end
                default: begin
                    state_n = OB_IDLE;
                end
            endcase
        end

        out_valid_n = (state_n == OB_STREAM);
        out_last_n  = (state_n == OB_STREAM) &&
                      (u_n == U_W'(m_lat_n - M_W'(1))) &&
                      (b_n == B_W'(W - 1));
    end

    // Serialiser registers, including the registered stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= OB_IDLE;
            m_lat     <= M_W'(M_MAX);
            u         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            m_lat     <= m_lat_n;
            u         <= u_n;
            b         <= b_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            out_data  <= out_data_n;
        end
    end

`ifdef OUTBUF_STATS_EN
    // Statistics survive outbuf_clr; only rstn clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
            stat_ovf    <= 1'b0;
        end else begin
            if (push) begin
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            end
            if (pop) begin
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            end
            if (eng_outbuf_wr_req && fifo_full) begin
                stat_ovf <= 1'b1;
            end
        end
    end
`endif

endmodule
